sync_fifo_ptr: RTL and testbench



---
 rtl/sync_fifo_ptr.sv | 124 ++++++++++++
 tb/tb_sync_fifo_ptr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: synchronous FIFO with valid/ready handshakes on both sides.
// Pointers wrap explicitly at Depth-1, so any Depth is supported, not only
// powers of two. Depth==0 builds a purely combinational pass-through.
//
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   rst_i     synchronous active-high reset
//   clr_i     synchronous flush, empties the FIFO
//   wvalid_i  write request          wready_o  FIFO can accept a write
//   wdata_i   write data
//   rvalid_o  head data available    rready_i  consumer takes head data
//   rdata_o   head data, zero while empty
//   full_o    occupancy == Depth
//   depth_o   occupancy zero-extended to 32 bits
module sync_fifo_ptr #(
    parameter int Width = 8,
    parameter int Depth = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic [31:0]      depth_o
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntWidth = $clog2(Depth + 1);

    generate
        if (Depth == 0) begin : g_pass
            // No storage: the handshake simply connects producer to consumer.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk_i, rst_i, clr_i};
            assign wready_o    = rready_i;
            assign rvalid_o    = wvalid_i;
            assign rdata_o     = wdata_i;
            assign full_o      = 1'b0;
            assign depth_o     = 32'd0;
        end else begin : g_fifo
            logic [Width-1:0]    mem_q [Depth];
            logic [PtrWidth-1:0] wptr_q, wptr_d;
            logic [PtrWidth-1:0] rptr_q, rptr_d;
            logic [CntWidth-1:0] cnt_q, cnt_d;
            logic                push, pop, empty;

            // Explicit wrap keeps pointers inside 0..Depth-1 for any Depth.
            function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
                if (p == PtrWidth'(Depth - 1)) begin
                    return '0;
                end
                return p + PtrWidth'(1);
            endfunction

            assign empty    = (cnt_q == '0);
            assign full_o   = (cnt_q == CntWidth'(Depth));
            // Ready/valid come from registered state only, never from the
            // other side's request, so a full FIFO cannot accept a write even
            // when a pop happens in the same cycle.
            assign wready_o = !full_o;
            assign rvalid_o = !empty;
            assign push     = wvalid_i & wready_o;
            assign pop      = rvalid_o & rready_i;
            assign rdata_o  = empty ? '0 : mem_q[rptr_q];
            assign depth_o  = 32'(cnt_q);

            always_comb begin
                wptr_d = wptr_q;
                rptr_d = rptr_q;
                cnt_d  = cnt_q;
                if (clr_i) begin
                    wptr_d = '0;
                    rptr_d = '0;
                    cnt_d  = '0;
                end else begin
                    if (push) wptr_d = ptr_inc(wptr_q);
                    if (pop)  rptr_d = ptr_inc(rptr_q);
                    if (push && !pop) begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end else if (pop && !push) begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                    cnt_q  <= cnt_d;
                end
            end

            // Storage is not reset; contents are only visible through rptr/cnt.
            always_ff @(posedge clk_i) begin
                if (push && !clr_i && !rst_i) begin
                    mem_q[wptr_q] <= wdata_i;
                end
            end

`ifndef SYNTHESIS
            always @(posedge clk_i) begin
                if (!rst_i) begin
                    assert (int'(cnt_q) <= Depth)   else $error("count above Depth");
                    assert (int'(wptr_q) < Depth)   else $error("wptr out of range");
                    assert (int'(rptr_q) < Depth)   else $error("rptr out of range");
                    assert (!(push && full_o))      else $error("push while full");
                    assert (!(pop && empty))        else $error("pop while empty");
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ptr.sv
module tb_sync_fifo_ptr;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- Depth=5 instance ----------------
    logic rst5, clr5, wv5, rr5, wready5, rvalid5, full5;
    logic [7:0] wd5, rdata5;
    logic [31:0] depth5;
    logic [7:0] q5[$];

    sync_fifo_ptr #(.Width(8), .Depth(5)) dut5 (
        .clk_i(clk), .rst_i(rst5), .clr_i(clr5),
        .wvalid_i(wv5), .wready_o(wready5), .wdata_i(wd5),
        .rvalid_o(rvalid5), .rready_i(rr5), .rdata_o(rdata5),
        .full_o(full5), .depth_o(depth5)
    );

    // ---------------- sweep instances ----------------
    logic rst_s, clr_s;
    logic wv1, rr1, wready1, rvalid1, full1;
    logic [7:0] wd1, rdata1;
    logic [31:0] depth1;
    logic wv8, rr8, wready8, rvalid8, full8;
    logic [7:0] wd8, rdata8;
    logic [31:0] depth8;
    logic wv0, rr0, wready0, rvalid0, full0;
    logic [7:0] wd0, rdata0;
    logic [31:0] depth0;
    logic [7:0] q1[$];
    logic [7:0] q8[$];

    sync_fifo_ptr #(.Width(8), .Depth(1)) dut1 (
        .clk_i(clk), .rst_i(rst_s), .clr_i(clr_s),
        .wvalid_i(wv1), .wready_o(wready1), .wdata_i(wd1),
        .rvalid_o(rvalid1), .rready_i(rr1), .rdata_o(rdata1),
        .full_o(full1), .depth_o(depth1)
    );

    sync_fifo_ptr #(.Width(8), .Depth(8)) dut8 (
        .clk_i(clk), .rst_i(rst_s), .clr_i(clr_s),
        .wvalid_i(wv8), .wready_o(wready8), .wdata_i(wd8),
        .rvalid_o(rvalid8), .rready_i(rr8), .rdata_o(rdata8),
        .full_o(full8), .depth_o(depth8)
    );

    sync_fifo_ptr #(.Width(8), .Depth(0)) dut0 (
        .clk_i(clk), .rst_i(rst_s), .clr_i(clr_s),
        .wvalid_i(wv0), .wready_o(wready0), .wdata_i(wd0),
        .rvalid_o(rvalid0), .rready_i(rr0), .rdata_o(rdata0),
        .full_o(full0), .depth_o(depth0)
    );

    // One Depth=5 cycle: drive, check head/handshake against the reference
    // queue before the edge, update the queue at the edge, check occupancy.
    task automatic cyc5(input bit rst, input bit clr, input bit wv, input bit rr,
                        input logic [7:0] wd);
        bit do_push, do_pop;
        rst5 = rst; clr5 = clr; wv5 = wv; rr5 = rr; wd5 = wd;
        #1;
        if (!rst) begin
            chk("d5_rvalid", rvalid5, q5.size() != 0);
            chk("d5_wready", wready5, q5.size() != 5);
            chk("d5_rdata",  rdata5,  (q5.size() != 0) ? q5[0] : 8'h00);
        end
        @(posedge clk);
        do_pop  = rr && (q5.size() != 0);
        do_push = wv && (q5.size() != 5);
        if (rst || clr) begin
            q5.delete();
        end else begin
            if (do_pop)  void'(q5.pop_front());
            if (do_push) q5.push_back(wd);
        end
        #1;
        chk("d5_depth", depth5, q5.size());
        chk("d5_full",  full5,  q5.size() == 5);
    endtask

    typedef struct {
        bit         rst, clr, wv, rr;
        logic [7:0] wd;
        int         dep;
        bit         full;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, bit clr, bit wv, bit rr, logic [7:0] wd,
                                int dep, bit full, logic [7:0] rd);
        vec_t v;
        v.rst = rst; v.clr = clr; v.wv = wv; v.rr = rr; v.wd = wd;
        v.dep = dep; v.full = full; v.rd = rd;
        tbl.push_back(v);
    endfunction

    initial begin
        rst_s = 1'b1; clr_s = 1'b0;
        wv1 = 0; rr1 = 0; wd1 = 0;
        wv8 = 0; rr8 = 0; wd8 = 0;
        wv0 = 0; rr0 = 0; wd0 = 0;

        // Post-edge expectations: depth_o, full_o, rdata_o.
        add(1,0,0,0,8'h00, 0,0,8'h00);
        add(1,0,0,0,8'h00, 0,0,8'h00);
        add(0,0,0,1,8'h00, 0,0,8'h00);
        add(0,0,0,1,8'h00, 0,0,8'h00);
        add(0,0,0,1,8'h00, 0,0,8'h00);
        add(0,0,1,0,8'h11, 1,0,8'h11);
        add(0,0,1,0,8'h22, 2,0,8'h11);
        add(0,0,1,0,8'h33, 3,0,8'h11);
        add(0,0,1,0,8'h44, 4,0,8'h11);
        add(0,0,1,0,8'h55, 5,1,8'h11);
        add(0,0,1,0,8'h66, 5,1,8'h11);
        add(0,0,0,1,8'h00, 4,0,8'h22);
        add(0,0,0,1,8'h00, 3,0,8'h33);
        add(0,0,0,1,8'h00, 2,0,8'h44);
        add(0,0,1,0,8'hA0, 3,0,8'h44);
        add(0,0,1,0,8'hA1, 4,0,8'h44);
        add(0,0,1,0,8'hA2, 5,1,8'h44);
        add(0,0,0,1,8'h00, 4,0,8'h55);
        add(0,0,0,1,8'h00, 3,0,8'hA0);
        add(0,0,0,1,8'h00, 2,0,8'hA1);
        add(0,0,0,1,8'h00, 1,0,8'hA2);
        add(0,0,0,1,8'h00, 0,0,8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc5(tbl[i].rst, tbl[i].clr, tbl[i].wv, tbl[i].rr, tbl[i].wd);
            chk("tbl_depth",  depth5,  tbl[i].dep);
            chk("tbl_full",   full5,   tbl[i].full);
            chk("tbl_wready", wready5, !tbl[i].full);
            chk("tbl_rvalid", rvalid5, tbl[i].dep != 0);
            chk("tbl_rdata",  rdata5,  tbl[i].rd);
        end

        // Simultaneous push/pop at occupancy 2.
        cyc5(0,0,1,0,8'hB0);
        cyc5(0,0,1,0,8'hB1);
        for (int i = 0; i < 10; i++) begin
            cyc5(0,0,1,1,8'(8'hC0 + i));
            chk("sim_depth", depth5, 2);
        end
        cyc5(0,0,0,1,8'h00);
        cyc5(0,0,0,1,8'h00);
        chk("sim_drained", depth5, 0);

        // Push into empty with rready high: no bypass.
        cyc5(0,0,1,1,8'hD0);
        chk("nobypass_rvalid", rvalid5, 1);
        chk("nobypass_rdata",  rdata5,  8'hD0);
        cyc5(0,0,0,1,8'h00);

        // Flush with a concurrent push at occupancy 3.
        cyc5(0,0,1,0,8'hE0);
        cyc5(0,0,1,0,8'hE1);
        cyc5(0,0,1,0,8'hE2);
        chk("pre_clr_depth", depth5, 3);
        cyc5(0,1,1,0,8'hEE);
        chk("clr_depth",  depth5,  0);
        chk("clr_rvalid", rvalid5, 0);

        // Reset with a concurrent push at occupancy 4.
        for (int i = 0; i < 4; i++) cyc5(0,0,1,0,8'(8'hF0 + i));
        chk("pre_rst_depth", depth5, 4);
        cyc5(1,0,1,0,8'hFF);
        chk("rst_depth",  depth5,  0);
        chk("rst_rvalid", rvalid5, 0);
        chk("rst_rdata",  rdata5,  8'h00);
        cyc5(0,0,0,0,8'h00);
        chk("post_rst_empty", rvalid5, 0);
        cyc5(0,0,1,0,8'h5A);
        chk("post_rst_head", rdata5, 8'h5A);

        // Random sweep: Depth=1, Depth=8, Depth=0.
        rst_s = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bit p1, o1, p8, o8;
            clr_s = ($urandom_range(0, 40) == 0);
            wv1 = 1'($urandom_range(0, 1)); rr1 = 1'($urandom_range(0, 1)); wd1 = 8'($urandom);
            wv8 = 1'($urandom_range(0, 1)); rr8 = 1'($urandom_range(0, 1)); wd8 = 8'($urandom);
            wv0 = 1'($urandom_range(0, 1)); rr0 = 1'($urandom_range(0, 1)); wd0 = 8'($urandom);
            #1;
            chk("d1_rvalid", rvalid1, q1.size() != 0);
            chk("d1_wready", wready1, q1.size() != 1);
            chk("d1_rdata",  rdata1,  (q1.size() != 0) ? q1[0] : 8'h00);
            chk("d8_rvalid", rvalid8, q8.size() != 0);
            chk("d8_wready", wready8, q8.size() != 8);
            chk("d8_rdata",  rdata8,  (q8.size() != 0) ? q8[0] : 8'h00);
            chk("d0_rdata",  rdata0,  wd0);
            chk("d0_rvalid", rvalid0, wv0);
            chk("d0_wready", wready0, rr0);
            chk("d0_depth",  depth0,  0);
            chk("d0_full",   full0,   0);
            @(posedge clk);
            o1 = rr1 && (q1.size() != 0); p1 = wv1 && (q1.size() != 1);
            o8 = rr8 && (q8.size() != 0); p8 = wv8 && (q8.size() != 8);
            if (clr_s) begin
                q1.delete();
                q8.delete();
            end else begin
                if (o1) void'(q1.pop_front());
                if (p1) q1.push_back(wd1);
                if (o8) void'(q8.pop_front());
                if (p8) q8.push_back(wd8);
            end
            #1;
            chk("d1_depth", depth1, q1.size());
            chk("d1_full",  full1,  q1.size() == 1);
            chk("d8_depth", depth8, q8.size());
            chk("d8_full",  full8,  q8.size() == 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
